// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF engine.
// Holds the FSM state encoding and the 8-bit Galois scrambler step.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        COMPARE,
        DONE
    } state_t;

    localparam logic [7:0] LFSR_MASK  = 8'hB8;
    localparam logic [7:0] ZERO_SEED  = 8'hB8;
    localparam int         SETTLE_CYC = 2;

    // Galois form of x^8+x^6+x^5+x^4+1: shift right, fold the mask in on a 1 out.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one oscillator line, detects rising edges and counts them
// into a saturating counter that is cleared while the engine settles.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             din,
    output logic [CNT_W-1:0] count
);

    logic sync0;
    logic sync1;
    logic hist;
    logic rise;

    assign rise = sync1 & ~hist;

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync0 <= din;
            sync1 <= sync0;
            // While clearing, hist tracks sync0 so the first counting cycle
            // never sees a false edge left over from the previously selected line.
            hist  <= clr ? sync0 : sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (cnt_en && rise && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ro_puf_engine.sv
// Serialized RO PUF: scrambles the challenge with an LFSR, races one bank-A
// oscillator against one bank-B oscillator per bit and packs the results.
module ro_puf_engine
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO = 16,
    parameter int RESP_W = 8,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        chall_in,
    input  logic [NUM_RO-1:0] ro_out,
    output logic              ro_en,
    output logic              busy,
    output logic              ready,
    output logic [RESP_W-1:0] response
);

    localparam int HALF  = NUM_RO / 2;
    localparam int SEL_W = $clog2(HALF);
    localparam int CYC_W = $clog2(WINDOW + 1);
    localparam int IDX_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;

    state_t             state;
    state_t             state_next;
    logic               start_ok;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [7:0]         lfsr;
    logic [7:0]         seed;
    logic [SEL_W-1:0]   sel_a;
    logic [SEL_W-1:0]   sel_b;
    logic [HALF-1:0]    bank_a;
    logic [HALF-1:0]    bank_b;
    logic [CNT_W-1:0]   cnt_a;
    logic [CNT_W-1:0]   cnt_b;

    assign seed   = (chall_in == 8'h00) ? ZERO_SEED : chall_in;
    assign bank_a = ro_out[HALF-1:0];
    assign bank_b = ro_out[NUM_RO-1:HALF];

    // The LFSR only changes on SETTLE entry (load or advance out of COMPARE),
    // so selections taken from it are stable from SETTLE through COMPARE.
    assign sel_a = lfsr[SEL_W-1:0];
    assign sel_b = lfsr[7 -: SEL_W];

    assign ro_en = (state == SETTLE) || (state == COUNT);
    assign busy  = (state == SETTLE) || (state == COUNT) || (state == COMPARE);
    assign ready = (state == DONE);

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = SETTLE;
                    start_ok   = 1'b1;
                end
            end
            SETTLE: begin
                if (cyc_cnt == CYC_W'(SETTLE_CYC - 1)) state_next = COUNT;
            end
            COUNT: begin
                if (cyc_cnt == CYC_W'(WINDOW - 1)) state_next = COMPARE;
            end
            COMPARE: begin
                state_next = (bit_idx == IDX_W'(RESP_W - 1)) ? DONE : SETTLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cyc_cnt <= '0;
        end else begin
            state <= state_next;
            if ((state_next != state) || !((state == SETTLE) || (state == COUNT))) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr     <= ZERO_SEED;
            bit_idx  <= '0;
            response <= '0;
        end else if (start_ok) begin
            lfsr     <= seed;
            bit_idx  <= '0;
            response <= '0;
        end else if (state == COMPARE) begin
            lfsr              <= lfsr_next(lfsr);
            response[bit_idx] <= (cnt_a > cnt_b);
            bit_idx           <= bit_idx + 1'b1;
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == SETTLE),
        .cnt_en (state == COUNT),
        .din    (bank_a[sel_a]),
        .count  (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == SETTLE),
        .cnt_en (state == COUNT),
        .din    (bank_b[sel_b]),
        .count  (cnt_b)
    );

endmodule

// File: tb/tb_ro_puf_engine.sv
// Randomized bench for ro_puf_engine: behavioural oscillators, a timeline and
// response model derived from the engine's rules, and a per-cycle compare.
module tb_ro_puf_engine;

    localparam int NUM_RO = 16;
    localparam int RESP_W = 8;
    localparam int WINDOW = 64;
    localparam int SLOT   = WINDOW + 3;
    localparam int LAT    = RESP_W * SLOT;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        chall_in = 8'h00;
    logic [NUM_RO-1:0] ro_out = '0;
    logic              ro_en, busy, ready;
    logic [RESP_W-1:0] response;
    logic              ro_en_s, busy_s, ready_s;
    logic [RESP_W-1:0] response_s;

    int per [NUM_RO];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ro_puf_engine #(.NUM_RO(NUM_RO), .RESP_W(RESP_W), .CNT_W(16), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .start(start), .chall_in(chall_in), .ro_out(ro_out),
        .ro_en(ro_en), .busy(busy), .ready(ready), .response(response)
    );

    ro_puf_engine #(.NUM_RO(NUM_RO), .RESP_W(RESP_W), .CNT_W(4), .WINDOW(WINDOW)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .chall_in(chall_in), .ro_out(ro_out),
        .ro_en(ro_en_s), .busy(busy_s), .ready(ready_s), .response(response_s)
    );

    // Square waves as a pure function of time; equal periods stay in phase,
    // and toggles never land on a clock edge.
    initial begin
        for (int i = 0; i < NUM_RO; i++) per[i] = 4;
        forever begin
            #1;
            for (int i = 0; i < NUM_RO; i++)
                ro_out[i] = ((($time + 3) / (5 * per[i])) % 2) != 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected response: per step the oscillator with more edges in the
    // window wins; edge count is roughly WINDOW/period, clipped by counter width.
    function automatic void model_response(input logic [7:0] c,
                                           output logic [7:0] r, output logic [7:0] rs);
        logic [7:0] l;
        int a, b, ca, cb;
        l = (c == 8'h00) ? 8'hB8 : c;
        r = '0;
        rs = '0;
        for (int i = 0; i < RESP_W; i++) begin
            a  = l % (NUM_RO / 2);
            b  = NUM_RO / 2 + (l >> 5);
            ca = WINDOW / per[a];
            cb = WINDOW / per[b];
            r[i]  = ca > cb;
            rs[i] = ((ca > 15) ? 15 : ca) > ((cb > 15) ? 15 : cb);
            l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
        end
    endfunction

    logic       m_busy = 1'b0, m_ready = 1'b0;
    logic [7:0] m_resp = '0, m_resp_s = '0, m_pend, m_pend_s;
    int         m_t = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_ready = 1'b0; m_resp = '0; m_resp_s = '0; m_t = 0;
        end else if (start && !m_busy) begin
            m_busy = 1'b1; m_ready = 1'b0; m_resp = '0; m_resp_s = '0; m_t = 0;
            model_response(chall_in, m_pend, m_pend_s);
        end else if (m_busy) begin
            m_t++;
            if (m_t == LAT) begin
                m_busy = 1'b0; m_ready = 1'b1; m_resp = m_pend; m_resp_s = m_pend_s;
            end
        end
    end

    always @(negedge clk) begin
        logic m_ro_en;
        m_ro_en = m_busy && ((m_t % SLOT) != SLOT - 1);
        check("busy", busy, m_busy);
        check("ro_en", ro_en, m_ro_en);
        check("ready", ready, m_ready);
        check("busy_sat", busy_s, m_busy);
        check("ready_sat", ready_s, m_ready);
        if (!m_busy || m_t < SLOT) begin
            check("response", response, m_resp);
            check("response_sat", response_s, m_resp_s);
        end
    end

    task automatic run(input logic [7:0] c, input int extra_at, output logic [7:0] r);
        int n;
        @(negedge clk);
        chall_in = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chall_in = 8'($urandom);
        n = 0;
        while (!ready && n < LAT + 100) begin
            @(negedge clk);
            n++;
            start = (n == extra_at);
        end
        start = 1'b0;
        check("latency", n, LAT);
        r = response;
    endtask

    task automatic set_banks(input int pa, input int pb);
        for (int i = 0; i < NUM_RO; i++) per[i] = (i < NUM_RO / 2) ? pa : pb;
    endtask

    task automatic randomize_periods();
        int opts [6] = '{2, 4, 6, 8, 12, 16};
        for (int i = 0; i < NUM_RO; i++) per[i] = opts[$urandom_range(0, 5)];
    endtask

    initial begin
        logic [7:0] r;
        set_banks(4, 6);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        run(8'h5A, -1, r);
        check("a_faster", r, 8'hFF);
        check("a_faster_sat", response_s, 8'hFF);
        set_banks(6, 4);
        run(8'h5A, -1, r);
        check("b_faster", r, 8'h00);
        set_banks(4, 4);
        run(8'h3C, -1, r);
        check("tie", r, 8'h00);

        randomize_periods();
        run(8'h00, -1, r);
        run(8'hB8, -1, r);
        for (int k = 0; k < 4; k++) begin
            randomize_periods();
            run(8'($urandom), -1, r);
        end

        randomize_periods();
        run(8'hA7, 150, r);

        @(negedge clk);
        chall_in = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * SLOT + 5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_ro_en", ro_en, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_response", response, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        run(8'h11, -1, r);

        set_banks(2, 2);
        run(8'h77, -1, r);
        check("sat_tie", response_s, 8'h00);
        set_banks(2, 16);
        run(8'h77, -1, r);
        check("sat_a_wins", response_s, 8'hFF);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ro_puf_engine.md
# ro_puf_engine

Parametrised serialized ring-oscillator PUF engine, next generation of the RO PUF top. It takes a challenge and seeds an LFSR scrambler from it. Per response bit, it picks one oscillator from bank A and one from bank B, counts synchronized rising edges of each over a programmable window, and compares the counts. Bits are assembled into a RESP_W-bit response, flagged by a `ready` handshake. The oscillators are instantiated at chip top; this block only enables them and counts their outputs.

## Interface
- NUM_RO, 16: total oscillators. Must be 4, 8, 16 or 32. Bank A is `ro_out[NUM_RO/2-1:0]`; bank B is the upper half.
- RESP_W, 8: response bits per challenge, 1..32.
- CNT_W, 16: edge-counter width. Counters saturate.
- WINDOW, 1024: COUNT-state length in clk cycles, ≥ 4.
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low. Clears all state.
- start, input, 1: single-cycle request. Accepted only in IDLE or DONE.
- chall_in, input, 8: challenge, sampled with an accepted start.
- ro_out, input, NUM_RO: raw oscillator outputs, asynchronous to clk.
- ro_en, output, 1: oscillator enable. High only in SETTLE and COUNT.
- busy, output, 1: high in SETTLE, COUNT and COMPARE.
- ready, output, 1: response valid. Held until the next accepted start or reset.
- response, output, RESP_W: assembled response. Bit i is the result of the i-th comparison.

## Operation
- **States:** IDLE → SETTLE (2 cycles) → COUNT (WINDOW cycles) → COMPARE (1 cycle). From COMPARE, go back to SETTLE if bit_idx < RESP_W-1, else to DONE. DONE → SETTLE on start.
- **Start acceptance:**
  - On accepted start: load LFSR with chall_in, or with 8'hB8 if chall_in == 0.
  - Also clear bit_idx, response and ready.
  - start in SETTLE, COUNT or COMPARE is ignored.
- **LFSR:** 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1 (mask 8'hB8). It advances exactly once per COMPARE.
- **Selection:** SEL_W = log2(NUM_RO/2).
  - sel_a = lfsr[SEL_W-1:0]; sel_b = lfsr[7:8-SEL_W].
  - Both are registered on SETTLE entry and held stable through COMPARE.
- **Edge path:**
  - Each selected line passes through a 2-FF synchronizer plus a history flop.
  - A rising edge is (sync & ~hist).
  - Counters clear in SETTLE and increment on an edge only in COUNT.
  - Counters saturate at 2^CNT_W-1.
- **Compare:** bit = (cnt_a > cnt_b), written to response[bit_idx] in COMPARE. A tie gives 0.
- **ro_en:** ro_en falling in COMPARE/DONE/IDLE stops oscillation. Synchronizer contents are discarded by the next SETTLE.

## Timing
- **Reset values:** response=0, ready=0, busy=0, ro_en=0, state=IDLE, lfsr=8'hB8, counters=0.
- **Start edge:** start is sampled at edge k. busy and ro_en are high from k+1.
- **Latency:** ready rises at edge k + RESP_W·(WINDOW+3). busy falls on the same edge.
- **Restart from DONE:** start accepted in DONE drops ready on the next edge. response clears on that same edge.
- **Reset mid-operation:** async deassert of all outputs. No partial response is retained.
- **Sync latency:** 2-cycle synchronizer latency is absorbed by SETTLE. Edges arriving in SETTLE are never counted.

## Structure
- **Package ro_puf_pkg:**
  - state enum (IDLE, SETTLE, COUNT, COMPARE, DONE)
  - LFSR_MASK=8'hB8, ZERO_SEED=8'hB8, SETTLE_CYC=2
  - function lfsr_next()
- **Sub-module ro_edge_counter:** used twice (bank A, bank B). It contains the sync chain, edge detect and saturating counter. Ports: clk, rst, clr, cnt_en, din, count.

## Test plan
Bench uses behavioural square-wave oscillators, NUM_RO=16, RESP_W=8, WINDOW=64, CNT_W=16 unless stated.
- **Reset:** hold rst=0 with toggling ro_out → response=0, ready=0, busy=0, ro_en=0 throughout.
- **Bank A faster:** bank A period 4 clk, bank B period 6 clk, start with chall 8'h5A → ready at start+536 cycles, response=8'hFF.
- **Bank B faster, then tie:** swap the periods → 8'h00. Equal periods of 4 → 8'h00 (tie rule).
- **Zero challenge and LFSR model:** chall 8'h00 gives the identical response to chall 8'hB8. A mixed-period oscillator set is checked bit-for-bit against a reference model of sel_a/sel_b per step.
- **Protocol and mid-run reset:**
  - A second start pulse mid-run is ignored; response and latency are unchanged.
  - rst asserted during COUNT of bit 3 → all outputs 0 immediately; a fresh start completes normally.
- **Saturation:** CNT_W=4, both banks period 2 → both counters stick at 15, tie → response=0. Then bank A period 2, bank B period 16 → response=8'hFF.
